// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and state encoding for the skid-buffered pipeline stage.
//   DEF_WIDTH : default payload width
//   NOP       : bubble value (MIPS NOP, all-zero)
//   state_e   : occupancy encoded as {skid_valid, main_valid}
package pipe_pkg;
    localparam int unsigned DEF_WIDTH = 32;
    localparam logic [DEF_WIDTH-1:0] NOP = '0;
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one payload register with valid bit.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   ld_i          : load d_i and mark valid
//   clr_i         : invalidate (wins over ld_i)
//   v_o, q_o      : valid bit and held payload
module pipe_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ld_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             v_o,
    output logic [WIDTH-1:0] q_o
);
    logic             v_q, v_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        v_d    = clr_i ? 1'b0 : ld_i ? 1'b1 : v_q;
        data_d = (ld_i && !clr_i) ? d_i : data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign v_o = v_q;
    assign q_o = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-slot skid-buffered pipeline stage with flush and stall counter.
//   clk, rst (async active-low), flush (sync squash)
//   in_valid/in_ready/in_data    : upstream handshake
//   out_valid/out_ready/out_data : downstream handshake, out_data=BUBBLE when idle
//   stall_cnt                    : saturating count of back-pressured cycles
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = DEF_WIDTH,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(NOP),
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);
    logic             main_v, skid_v;
    logic [WIDTH-1:0] main_q, skid_q, main_d;
    logic             main_ld, main_clr, skid_ld, skid_clr;
    logic             accept, drain;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state;

    // Occupancy is implied by the two valid bits; no separate state register.
    assign state = state_e'({skid_v, main_v});

    // in_ready depends only on a flop, so out_ready never reaches it combinationally.
    assign in_ready = ~skid_v;
    assign accept   = in_valid & in_ready & ~flush;
    assign drain    = main_v & out_ready;

    always_comb begin
        main_d   = (state == FULL) ? skid_q : in_data;
        main_ld  = (state == EMPTY) ? accept :
                   (state == ONE)   ? (accept & drain) :
                                      ((state == FULL) & drain);
        main_clr = flush | ((state == ONE) & drain & ~accept);
        skid_ld  = (state == ONE) & accept & ~drain;
        skid_clr = flush | ((state == FULL) & drain);
        cnt_d    = (main_v && !out_ready && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    pipe_slot #(.WIDTH(WIDTH)) u_main (
        .clk_i (clk),
        .rst_ni(rst),
        .ld_i  (main_ld),
        .clr_i (main_clr),
        .d_i   (main_d),
        .v_o   (main_v),
        .q_o   (main_q)
    );

    pipe_slot #(.WIDTH(WIDTH)) u_skid (
        .clk_i (clk),
        .rst_ni(rst),
        .ld_i  (skid_ld),
        .clr_i (skid_clr),
        .d_i   (in_data),
        .v_o   (skid_v),
        .q_o   (skid_q)
    );

    // Counter is deliberately untouched by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign out_valid = main_v;
    assign out_data  = main_v ? main_q : BUBBLE;
    assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed stimulus, queue-based reference model, per-cycle compare.
module tb_pipe_stage_skid;
    localparam int W     = 32;
    localparam int CW    = 4;
    localparam int SMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, in_valid, out_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_skid #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference: the stage is a FIFO of depth two with a saturating stall counter.
    logic [W-1:0] q[$];
    int           m_cnt = 0;
    logic         m_acc, m_drn;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            m_acc = in_valid && (q.size() < 2) && !flush;
            m_drn = (q.size() > 0) && out_ready;
            if ((q.size() > 0) && !out_ready && m_cnt < SMAX) m_cnt++;
            if (flush) q.delete();
            else begin
                if (m_drn) void'(q.pop_front());
                if (m_acc) q.push_back(in_data);
            end
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("out_valid", W'(out_valid), W'(q.size() > 0));
        chk("out_data", out_data, (q.size() > 0) ? q[0] : '0);
        chk("in_ready", W'(in_ready), W'(q.size() < 2));
        chk("stall_cnt", W'(stall_cnt), W'(m_cnt));
    end

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_in_ready", W'(in_ready), 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall", W'(stall_cnt), 0);
        rst = 1'b1;

        // single entry, one-cycle latency
        cyc(1'b1, 32'h11111111, 1'b1, 1'b0);
        chk("lat_valid", W'(out_valid), 1);
        chk("lat_data", out_data, 32'h11111111);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("lat_empty", W'(out_valid), 0);

        // back-to-back stream
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, W'(i), 1'b1, 1'b0);
            chk("stream_data", out_data, W'(i));
            chk("stream_ready", W'(in_ready), 1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);

        // skid fill and ordered drain
        cyc(1'b1, 32'h9, 1'b0, 1'b0);
        cyc(1'b1, 32'hA, 1'b0, 1'b0);
        chk("skid_ready", W'(in_ready), 0);
        cyc(1'b1, 32'hB, 1'b0, 1'b0);
        chk("skid_hold", out_data, 32'h9);
        chk("skid_stall", W'(stall_cnt), 2);
        cyc(1'b1, 32'hB, 1'b1, 1'b0);
        chk("drain_a", out_data, 32'hA);
        chk("drain_ready", W'(in_ready), 1);
        cyc(1'b1, 32'hB, 1'b1, 1'b0);
        chk("drain_b", out_data, 32'hB);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // flush while FULL
        cyc(1'b1, 32'h21, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 1'b0, 1'b0);
        cyc(1'b1, 32'hC, 1'b1, 1'b1);
        chk("flush_valid", W'(out_valid), 0);
        chk("flush_data", out_data, 0);
        chk("flush_ready", W'(in_ready), 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("flush_no_c", W'(out_valid), 0);

        // stall counter saturation
        cyc(1'b1, 32'h31, 1'b0, 1'b0);
        repeat (20) cyc(1'b0, '0, 1'b0, 1'b0);
        chk("sat_15", W'(stall_cnt), 15);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("sat_flush", W'(stall_cnt), 15);

        // asynchronous reset while FULL
        cyc(1'b1, 32'h41, 1'b0, 1'b0);
        cyc(1'b1, 32'h42, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", W'(out_valid), 0);
        chk("arst_ready", W'(in_ready), 1);
        chk("arst_stall", W'(stall_cnt), 0);
        chk("arst_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, 32'h51, 1'b1, 1'b0);
        chk("post_rst", out_data, 32'h51);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // mixed traffic checked by the model
        for (int i = 0; i < 48; i++)
            cyc(i % 3 != 0, W'(32'h100 + i), i % 4 != 1, i == 29);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
